bcd_countdown_timer: RTL and testbench

//  3-digit BCD countdown timer (000-999 s) for one irrigation/service mode.

---
 rtl/bcd_countdown_timer.sv | 131 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer (000-999) for one service mode. A valid preset loads and
// starts the count, which decrements once per TICK_DIV cycles and pulses done at 000.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PW       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  input  logic        abort,
  input  logic [11:0] load_val,
  output logic [11:0] bcd,
  output logic        active,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [11:0]   bcd_q;
  logic          active_q;
  logic          done_q;
  logic          err_q;

  // Every nibble must be a decimal digit and a zero preset would never count.
  function automatic logic bcd_ok(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v != 12'h000);
  endfunction

  // Digit-wise decrement with borrow; callers never pass 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  logic        load_valid;
  logic        tick;
  logic        last_count;
  logic [11:0] bcd_next;

  assign load_valid = bcd_ok(load_val);
  assign tick       = (presc_q == PrescLast);
  assign last_count = (bcd_q == 12'h001) || (bcd_q == 12'h000);
  assign bcd_next   = bcd_dec(bcd_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      bcd_q    <= 12'h000;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (abort) begin
            bcd_q   <= 12'h000;
            presc_q <= '0;
          end else if (start) begin
            if (load_valid) begin
              bcd_q    <= load_val;
              presc_q  <= '0;
              active_q <= 1'b1;
              state_q  <= StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // A HOLD cycle with hold released counts like a RUN cycle, so no prescale step is lost.
        StRun, StHold: begin
          if (abort) begin
            bcd_q    <= 12'h000;
            presc_q  <= '0;
            active_q <= 1'b0;
            state_q  <= StIdle;
          end else if (hold) begin
            state_q <= StHold;
          end else begin
            state_q <= StRun;
            if (tick) begin
              presc_q <= '0;
              if (last_count) begin
                bcd_q    <= 12'h000;
                active_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= StDone;
              end else begin
                bcd_q <= bcd_next;
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bcd    = bcd_q;
  assign active = active_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV=4: a vector table of held inputs and
// expected outputs, followed by a hand-written full-countdown sequence.
module tb_bcd_countdown_timer;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic        abort;
  logic [11:0] load_val;
  logic [11:0] bcd;
  logic        active;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  bcd_countdown_timer #(
    .TICK_DIV(TD),
    .PW      (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hold    (hold),
    .abort   (abort),
    .load_val(load_val),
    .bcd     (bcd),
    .active  (active),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        hold;
    logic        abort;
    logic [11:0] load_val;
    int          ncyc;
    logic [11:0] e_bcd;
    logic        e_active;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic s, input logic h, input logic a,
                   input logic [11:0] lv, input int n, input logic [11:0] eb,
                   input logic ea, input logic ed, input logic ee);
    vec_t x;
    x.rst_n = r; x.start = s; x.hold = h; x.abort = a; x.load_val = lv; x.ncyc = n;
    x.e_bcd = eb; x.e_active = ea; x.e_done = ed; x.e_err = ee;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [11:0] eb, input logic ea,
                       input logic ed, input logic ee);
    tests++;
    if ({bcd, active, done, err} !== {eb, ea, ed, ee}) begin
      fails++;
      $display("FAIL %s: got bcd=%h active=%b done=%b err=%b, want bcd=%h active=%b done=%b err=%b",
               name, bcd, active, done, err, eb, ea, ed, ee);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic bcd_legal;

    rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; load_val = 12'h000;

    //  rst  st  hd  ab  load    n   bcd     act   done  err
    v(1'b0, 0, 0, 0, 12'h000, 2, 12'h000, 1'b0, 1'b0, 1'b0);  // reset state
    // 012 full countdown
    v(1'b1, 1, 0, 0, 12'h012, 1, 12'h012, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 3, 12'h012, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h011, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h010, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h009, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 35, 12'h001, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b1, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // 100 -> 099 -> 098, then abort without done
    v(1'b1, 1, 0, 0, 12'h100, 1, 12'h100, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h099, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h098, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 1, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // rejected presets, and start+abort in idle
    v(1'b1, 1, 0, 0, 12'h0A5, 1, 12'h000, 1'b0, 1'b0, 1'b1);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b1);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 1, 0, 1, 12'h123, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // hold mid-prescale keeps the partial tick
    v(1'b1, 1, 0, 0, 12'h005, 1, 12'h005, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 2, 12'h005, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 1, 0, 12'h000, 10, 12'h005, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h005, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h004, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 1, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // abort beats hold; start ignored in RUN and in DONE
    v(1'b1, 1, 0, 0, 12'h050, 1, 12'h050, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 2, 12'h050, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 1, 1, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'h003, 1, 12'h003, 1'b1, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'h999, 4, 12'h002, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 7, 12'h001, 1'b1, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'h005, 1, 12'h000, 1'b0, 1'b1, 1'b0);
    v(1'b1, 1, 0, 0, 12'h005, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // reset mid-run, then a clean 003 run
    v(1'b1, 1, 0, 0, 12'h321, 1, 12'h321, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 2, 12'h321, 1'b1, 1'b0, 1'b0);
    v(1'b0, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'h003, 1, 12'h003, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 3, 12'h003, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h002, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h001, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 4, 12'h000, 1'b0, 1'b1, 1'b0);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    // abort from HOLD, bad hundreds nibble
    v(1'b1, 1, 0, 0, 12'h200, 1, 12'h200, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 1, 0, 12'h000, 3, 12'h200, 1'b1, 1'b0, 1'b0);
    v(1'b1, 0, 1, 1, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);
    v(1'b1, 1, 0, 0, 12'hA00, 1, 12'h000, 1'b0, 1'b0, 1'b1);
    v(1'b1, 0, 0, 0, 12'h000, 1, 12'h000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n    = vecs[i].rst_n;
      start    = vecs[i].start;
      hold     = vecs[i].hold;
      abort    = vecs[i].abort;
      load_val = vecs[i].load_val;
      repeat (vecs[i].ncyc) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_bcd, vecs[i].e_active, vecs[i].e_done,
            vecs[i].e_err);
    end

    // Full 010 countdown: done must arrive exactly 10 ticks after the load edge,
    // with every digit legal on the way down.
    start = 1'b1; load_val = 12'h010;
    @(posedge clk); #1;
    start = 1'b0; load_val = 12'h000;
    cyc = 0;
    bcd_legal = 1'b1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) bcd_legal = 1'b0;
    end
    tests++;
    if (cyc != 10 * TD) begin
      fails++;
      $display("FAIL seq_done_latency: got %0d cycles, want %0d", cyc, 10 * TD);
    end
    tests++;
    if (!bcd_legal) begin
      fails++;
      $display("FAIL seq_bcd_digits: got an illegal nibble on bcd, want digits 0-9 only");
    end
    check("seq_done_cycle", 12'h000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("seq_after_done", 12'h000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
